mem_port: RTL and testbench

MEM_PORT -- requirements
Module: mem_port

---
 rtl/mem_port.sv | 114 +++++++++++
 tb/tb_mem_port.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_port.sv
// Single-port word memory behind a valid/ready request channel with a fixed-latency read response.
// Build option: define MEM_PORT_BYTEEN_EN to honour reqBe on writes; otherwise writes replace the whole word.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | ready for a request; writes complete here in one cycle
// S_WAIT | read accepted, counting down the RDLAT wait cycles
// S_RESP | read response presented, held until rspValid && rspReady
module mem_port #(
  parameter  int DWIDTH = 32,
  parameter  int ADEPTH = 256,
  parameter  int RDLAT  = 2,
  localparam int AWIDTH = $clog2(ADEPTH),
  localparam int BWIDTH = DWIDTH / 8
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWr,
  input  logic [AWIDTH-1:0] reqAddr,
  input  logic [DWIDTH-1:0] reqData,
  input  logic [BWIDTH-1:0] reqBe,
  output logic              rspValid,
  input  logic              rspReady,
  output logic [DWIDTH-1:0] rspData,
  output logic              rspErr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [AWIDTH:0] DEPTH_W   = (AWIDTH + 1)'(ADEPTH);
  localparam logic [3:0]      WAIT_LOAD = (RDLAT > 0) ? 4'(RDLAT - 1) : 4'd0;
  localparam state_t          RD_NEXT   = (RDLAT > 0) ? S_WAIT : S_RESP;

  state_t            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [AWIDTH-1:0] addr_q;
  logic              err_q;
  logic              accept;
  logic              req_in_range;
  logic [DWIDTH-1:0] mem [ADEPTH];

  assign accept       = reqValid && (state_q == S_IDLE);
  assign req_in_range = {1'b0, reqAddr} < DEPTH_W;

  // Storage is deliberately outside the reset domain so a reset never disturbs contents.
  always_ff @(posedge clk) begin
    if (accept && reqWr && req_in_range) begin
`ifdef MEM_PORT_BYTEEN_EN
      for (int b = 0; b < BWIDTH; b++) begin
        if (reqBe[b]) mem[reqAddr][8*b +: 8] <= reqData[8*b +: 8];
      end
`else
      mem[reqAddr] <= reqData;
`endif
    end
  end

`ifndef MEM_PORT_BYTEEN_EN
  logic unused_be;
  assign unused_be = ^reqBe;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 4'd0;
      addr_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (accept && !reqWr) begin
        addr_q <= reqAddr;
        err_q  <= !req_in_range;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    reqReady   = 1'b0;
    rspValid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        reqReady = 1'b1;
        if (reqValid && !reqWr) begin
          state_d    = RD_NEXT;
          wait_cnt_d = WAIT_LOAD;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 4'd0) state_d = S_RESP;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end
      S_RESP: begin
        rspValid = 1'b1;
        if (rspReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // No writes can be accepted outside IDLE, so the addressed word is still the one seen at accept.
  assign rspData = (state_q == S_RESP && !err_q) ? mem[addr_q] : '0;
  assign rspErr  = (state_q == S_RESP) && err_q;

endmodule

// File: tb/tb_mem_port.sv
// Bench for mem_port: instance 0 has ADEPTH=200/RDLAT=2, instance 1 has ADEPTH=256/RDLAT=0.
// Expected responses come from a word-array model of each memory updated by the write rules.
module tb_mem_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN;
  logic        reqValid[2], reqReady[2], reqWr[2];
  logic        rspValid[2], rspReady[2], rspErr[2];
  logic [7:0]  reqAddr[2];
  logic [31:0] reqData[2], rspData[2];
  logic [3:0]  reqBe[2];

  mem_port #(.DWIDTH(32), .ADEPTH(200), .RDLAT(2)) dut (
    .clk(clk), .rstN(rstN),
    .reqValid(reqValid[0]), .reqReady(reqReady[0]), .reqWr(reqWr[0]),
    .reqAddr(reqAddr[0]), .reqData(reqData[0]), .reqBe(reqBe[0]),
    .rspValid(rspValid[0]), .rspReady(rspReady[0]), .rspData(rspData[0]), .rspErr(rspErr[0])
  );

  mem_port #(.DWIDTH(32), .ADEPTH(256), .RDLAT(0)) dut0 (
    .clk(clk), .rstN(rstN),
    .reqValid(reqValid[1]), .reqReady(reqReady[1]), .reqWr(reqWr[1]),
    .reqAddr(reqAddr[1]), .reqData(reqData[1]), .reqBe(reqBe[1]),
    .rspValid(rspValid[1]), .rspReady(rspReady[1]), .rspData(rspData[1]), .rspErr(rspErr[1])
  );

`ifdef MEM_PORT_BYTEEN_EN
  localparam bit BYTEEN = 1'b1;
`else
  localparam bit BYTEEN = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc[2];
  logic [31:0] mdl[2][256];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int depth_of(int s);
    return (s == 0) ? 200 : 256;
  endfunction

  function automatic int lat_of(int s);
    return (s == 0) ? 2 : 0;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_wr(int s, int a, logic [31:0] d, logic [3:0] be);
    logic [31:0] mask;
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{be[b] | ~BYTEEN}};
    if (a < depth_of(s)) mdl[s][a] = (mdl[s][a] & ~mask) | (d & mask);
  endtask

  task automatic do_write(int s, int a, logic [31:0] d, logic [3:0] be);
    reqValid[s] = 1'b1; reqWr[s] = 1'b1; reqAddr[s] = 8'(a); reqData[s] = d; reqBe[s] = be;
    #1 check("wr_ready", reqReady[s], 1);
    @(posedge clk);
    #1 reqValid[s] = 1'b0; reqWr[s] = 1'b0;
    model_wr(s, a, d, be);
    @(negedge clk);
    check("wr_no_rsp", {rspValid[s], reqReady[s]}, 2'b01);
  endtask

  task automatic do_read(int s, int a, int hold);
    logic [31:0] ed;
    logic        ee;
    int          j;
    ee = (a >= depth_of(s));
    ed = ee ? 32'd0 : mdl[s][a];
    reqValid[s] = 1'b1; reqWr[s] = 1'b0; reqAddr[s] = 8'(a); rspReady[s] = 1'b0;
    #1 check("rd_ready", reqReady[s], 1);
    @(posedge clk);
    #1 reqValid[s] = 1'b0;
    last_acc[s] = cyc;
    for (j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (rspValid[s]) break;
      check("wait_busy", reqReady[s], 0);
      check("wait_quiet", {rspErr[s], rspData[s]}, 0);
      @(posedge clk);
    end
    check("rd_latency", j, lat_of(s) + 1);
    check("rd_err", rspErr[s], ee);
    check("rd_data", rspData[s], ed);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", rspValid[s], 1);
      check("hold_data", {rspErr[s], rspData[s]}, {ee, ed});
      check("hold_busy", reqReady[s], 0);
    end
    rspReady[s] = 1'b1;
    @(posedge clk);
    #1 rspReady[s] = 1'b0;
    @(negedge clk);
    check("post_idle", {rspValid[s], reqReady[s]}, 2'b01);
    check("post_zero", {rspErr[s], rspData[s]}, 0);
  endtask

  initial begin
    int a1;
    rstN = 1'b0;
    for (int s = 0; s < 2; s++) begin
      reqValid[s] = 1'b0; reqWr[s] = 1'b0; reqAddr[s] = '0;
      reqData[s] = '0; reqBe[s] = '0; rspReady[s] = 1'b0; last_acc[s] = 0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++)
      check("reset_out", {rspValid[s], rspErr[s], rspData[s]}, 0);
    rstN = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) check("reset_ready", reqReady[s], 1);

    for (int s = 0; s < 2; s++)
      for (int a = 0; a < depth_of(s); a++) do_write(s, a, $urandom, 4'hF);

    do_write(0, 5, 32'hDEADBEEF, 4'hF);
    do_read(0, 5, 0);

    do_write(0, 7, 32'h11223344, 4'hF);
    do_write(0, 7, 32'hAABBCCDD, 4'b0101);
    do_read(0, 7, 0);

    do_write(0, 8, 32'h0BADF00D, 4'b0000);
    do_read(0, 8, 0);

    do_write(0, 250, 32'h55AA55AA, 4'hF);
    do_read(0, 250, 0);
    do_read(0, 199, 0);

    do_read(0, 5, 5);

    do_read(1, 1, 0);
    a1 = last_acc[1];
    do_read(1, 2, 0);
    check("b2b_spacing", last_acc[1] - a1, 2);

    reqValid[0] = 1'b1; reqWr[0] = 1'b0; reqAddr[0] = 8'd5;
    @(posedge clk);
    #1 reqValid[0] = 1'b0;
    @(negedge clk);
    rstN = 1'b0;
    #1 check("rst_mid_out", {rspValid[0], rspErr[0], rspData[0]}, 0);
    @(negedge clk);
    rstN = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rst_no_rsp", {rspValid[0], reqReady[0]}, 2'b01);
    end
    do_read(0, 5, 0);
    do_read(0, 7, 1);

    for (int i = 0; i < 80; i++) begin
      int s;
      int a;
      s = $urandom_range(0, 1);
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1) do_write(s, a, $urandom, 4'($urandom_range(0, 15)));
      else                          do_read(s, a, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
